mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles (legal 1..15).
REQ-003 Clocking: one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-004 clk  input  1  rising-edge clock shared with the pipeline.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 e_start  input  1  E-stage holds a valid MDU instruction this cycle; one-cycle pulse per instruction.
REQ-007 e_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6-7 reserved.
REQ-008 e_rs  input  32  forwarded rs operand in E.
REQ-009 e_rt  input  32  forwarded rt operand in E.
REQ-010 d_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 md_stall  output  1  stall request to the hazard unit, ORed with the existing stall.
REQ-013 hi  output  32  architectural HI register.
REQ-014 lo  output  32  architectural LO register.

Function
REQ-015 States: IDLE and RUN; a 4-bit down-counter cnt is active only in RUN.
REQ-016 IDLE with e_start and e_op in 0..3: latch e_op, e_rs, e_rt; load cnt with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3); go to RUN.
REQ-017 RUN: decrement cnt each cycle; when cnt=1, write the result to hi/lo and return to IDLE on the same edge.
REQ-018 Timing: start sampled at edge T gives busy=1 in cycles T+1..T+N, with N the op's cycle count; new hi/lo and busy=0 are visible from cycle T+N+1.
REQ-019 busy = (state==RUN), registered.
REQ-020 md_stall = d_md AND (busy OR e_start), combinational.
REQ-021 mult: signed 32x32 to 64-bit product; hi=product[63:32], lo=product[31:0].
REQ-022 multu: same as mult with unsigned operands.
REQ-023 div: signed; lo=quotient truncated toward zero; hi=remainder, sign of the dividend.
REQ-024 divu: unsigned; lo=quotient, hi=remainder.
REQ-025 Divisor zero (div or divu): hi/lo are unchanged; busy still runs the full DIV_CYCLES.
REQ-026 div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-027 mthi/mtlo in IDLE: write e_rs into hi/lo at the next edge; no RUN entry; busy stays 0.
REQ-028 e_start while in RUN: ignored, with no effect on state, cnt or hi/lo; md_stall makes this unreachable in normal use.
REQ-029 e_start with e_op 6 or 7: ignored.
REQ-030 hi/lo hold their value in all cases not listed above.

Reset
REQ-031 reset_n low: immediately, without waiting for clk, force state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the latched operands.
REQ-032 Reset asserted during RUN: abandon the operation with no hi/lo write; after release, the next e_start behaves as from a fresh IDLE.
REQ-033 md_stall = d_md AND e_start while reset_n is low; this equals 0 whenever e_start is low.

Verification
REQ-034 mult rs=0xFFFFFFFF, rt=2 at edge T -> busy=1 in T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFE from T+6.
REQ-035 multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-036 div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-037 d_md=1 held for cycles T..T+6 with a mult started at T -> md_stall=1 for T..T+5 and 0 at T+6; a second e_start at T+2 leaves the cnt sequence and the result unaffected.
REQ-038 mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0 throughout; reset_n pulsed low mid-div -> busy, hi and lo go to 0 asynchronously, and no later write occurs.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency busy window for mult/div with
// architectural HI/LO registers and a stall request to the pipeline hazard unit.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        e_start,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load, done;
  // op_q[1] selects divide, op_q[0] selects unsigned.
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (e_start && (e_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
          load    = 1'b1;
          state_d = RUN;
          cnt_d   = e_op[1] ? DIV_N : MULT_N;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the latched operands are plain flops, not a memory, so they are cleared
  // on reset like any other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (load) begin
      op_q <= e_op[1:0];
      a_q  <= e_rs;
      b_q  <= e_rt;
    end
  end

  // Multiply on 64-bit extended operands; the low 64 bits are exact for both
  // signed and unsigned interpretations.
  logic        is_signed;
  logic [63:0] ma, mb, prod;
  assign is_signed = ~op_q[0];
  assign ma   = {{32{is_signed & a_q[31]}}, a_q};
  assign mb   = {{32{is_signed & b_q[31]}}, b_q};
  assign prod = ma * mb;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
  logic        sa, sb;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, quo, rem;
  assign sa    = is_signed & a_q[31];
  assign sb    = is_signed & b_q[31];
  assign abs_a = sa ? (32'd0 - a_q) : a_q;
  assign abs_b = sb ? (32'd0 - b_q) : b_q;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign quo   = (sa ^ sb) ? (32'd0 - q_mag) : q_mag;
  assign rem   = sa ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (!op_q[1]) begin
        hi <= prod[63:32];
        lo <= prod[31:0];
      end else if (b_q != 32'd0) begin
        hi <= rem;
        lo <= quo;
      end
    end else if (state_q == IDLE && e_start) begin
      if (e_op == OP_MTHI) hi <= e_rs;
      if (e_op == OP_MTLO) lo <= e_rs;
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = d_md & (busy | e_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl: expected HI/LO and busy lengths are
// queued at issue time and checked by a monitor when busy drops.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        e_start;
  logic [2:0]  e_op;
  logic [31:0] e_rs, e_rt;
  logic        d_md;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .e_start  (e_start),
    .e_op     (e_op),
    .e_rs     (e_rs),
    .e_rt     (e_rt),
    .d_md     (d_md),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Reference model: HI/LO update rules written directly as integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32];
        l = p[31:0];
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        h  = pu[63:32];
        l  = pu[31:0];
      end
      3'd2: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'd0;
          end else begin
            sa = a;
            sb = b;
            l  = sa / sb;
            h  = sa % sb;
          end
        end
      end
      3'd3: begin
        if (b != 32'd0) begin
          l = a / b;
          h = a % b;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  function automatic int cycles_of(input logic [2:0] op);
    if (op <= 3'd1) return MC;
    if (op <= 3'd3) return DC;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: tracks busy runs and compares against the queue head when busy drops.
  int   run_len   = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      run_len   = 0;
      busy_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (busy) begin
        run_len++;
        if (exp_q.size() != 0) begin
          check({exp_q[0].name, " hi hold"}, hi, exp_q[0].pre_hi);
          check({exp_q[0].name, " lo hold"}, lo, exp_q[0].pre_lo);
        end
      end else if (busy_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected busy run: got %0d cycles, want none", run_len);
        end else begin
          e = exp_q.pop_front();
          check({e.name, " busy len"}, 32'(run_len), 32'(e.cycles));
          check({e.name, " hi"}, hi, e.hi);
          check({e.name, " lo"}, lo, e.lo);
        end
        run_len = 0;
      end
      busy_prev = busy;
    end
  end

  // Issue one instruction; inject > 0 raises a stray e_start in that busy cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd, input int inject);
    exp_t e;
    int   n;
    n = cycles_of(op);
    @(posedge clk); #1;
    e_start = 1'b1;
    e_op    = op;
    e_rs    = a;
    e_rt    = b;
    d_md    = dmd;
    e.name   = name;
    e.pre_hi = m_hi;
    e.pre_lo = m_lo;
    model(op, a, b, m_hi, m_lo);
    e.hi     = m_hi;
    e.lo     = m_lo;
    e.cycles = n;
    if (n > 0) exp_q.push_back(e);
    @(negedge clk);
    check_bit({name, " stall at start"}, md_stall, dmd);
    check_bit({name, " idle at start"}, busy, 1'b0);
    @(posedge clk); #1;
    e_start = 1'b0;
    e_rs    = $urandom;
    e_rt    = $urandom;
    for (int k = 1; k <= n; k++) begin
      if (k == inject) begin
        e_start = 1'b1;
        e_op    = 3'($urandom_range(0, 5));
      end
      @(negedge clk);
      check_bit({name, " busy"}, busy, 1'b1);
      check_bit({name, " stall busy"}, md_stall, dmd);
      @(posedge clk); #1;
      e_start = 1'b0;
    end
    @(negedge clk);
    check_bit({name, " busy done"}, busy, 1'b0);
    check_bit({name, " stall done"}, md_stall, 1'b0);
    check({name, " hi final"}, hi, m_hi);
    check({name, " lo final"}, lo, m_lo);
    d_md = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] th, tl;
    reset_n = 1'b1;
    e_start = 1'b0;
    e_op    = 3'd0;
    e_rs    = 32'd0;
    e_rt    = 32'd0;
    d_md    = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_bit("reset busy", busy, 1'b0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check_bit("reset stall no start", md_stall, 1'b0);
    e_start = 1'b1;
    #1 check_bit("reset stall with start", md_stall, 1'b1);
    e_start = 1'b0;
    d_md    = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    run_op("mult -1*2",     3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, 2);
    run_op("multu -1*2",    3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    run_op("div -7/2",      3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("divu 7/0",      3'd3, 32'd7, 32'd0, 1'b0, 3);
    run_op("div -7/0",      3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 0);
    run_op("div min/-1",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("mthi",          3'd4, 32'h1234_5678, 32'd0, 1'b1, 0);
    run_op("mtlo",          3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, 0);
    run_op("reserved 6",    3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1, 0);
    run_op("reserved 7",    3'd7, 32'hCAFE_F00D, 32'd1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
             1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    // Abort a divide with reset: HI/LO clear immediately and the result is never written.
    run_op("pre-reset mthi", 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0, 0);
    run_op("pre-reset mtlo", 3'd5, 32'h5A5A_5A5A, 32'd0, 1'b0, 0);
    @(posedge clk); #1;
    e_start = 1'b1;
    e_op    = 3'd3;
    e_rs    = 32'd100;
    e_rt    = 32'd7;
    e.name   = "aborted divu";
    e.pre_hi = m_hi;
    e.pre_lo = m_lo;
    th = m_hi;
    tl = m_lo;
    model(3'd3, 32'd100, 32'd7, th, tl);
    e.hi     = th;
    e.lo     = tl;
    e.cycles = DC;
    exp_q.push_back(e);
    @(posedge clk); #1 e_start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_bit("async reset busy", busy, 1'b0);
    check("async reset hi", hi, 32'd0);
    check("async reset lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k < DC + 2; k++) begin
      @(negedge clk);
      check_bit("post-reset idle", busy, 1'b0);
    end
    check("post-reset hi", hi, 32'd0);
    check("post-reset lo", lo, 32'd0);
    run_op("post-reset mult", 3'd0, 32'd3, 32'hFFFF_FFFC, 1'b1, 0);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
